// File: rtl/iddmm_ctrl_if.sv
// Handshake and operand-RAM address bundle between iddmm_ctrl, the modexp FSM and the IDDMM datapath.
// master = sequencer side (iddmm_ctrl); slave = environment side (modexp FSM, datapath, RAMs).
interface iddmm_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              busy;
  logic              done;
  logic              result_sel;
  logic              err;
  logic              fifo_clr;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [ADDR_W-1:0] y_rd_addr;
  logic [ADDR_W-1:0] p_rd_addr;
  logic [ADDR_W:0]   a_rd_addr;
  logic [ADDR_W-1:0] i_cnt;
  logic [ADDR_W:0]   j_cnt;
  logic              cal_done;
  logic              cal_sign;

  modport master (
    input  start, cal_done, cal_sign,
    output busy, done, result_sel, err, fifo_clr,
           x_rd_addr, y_rd_addr, p_rd_addr, a_rd_addr, i_cnt, j_cnt
  );

  modport slave (
    output start, cal_done, cal_sign,
    input  busy, done, result_sel, err, fifo_clr,
           x_rd_addr, y_rd_addr, p_rd_addr, a_rd_addr, i_cnt, j_cnt
  );
endinterface

// File: rtl/iddmm_ctrl.sv
// iddmm_ctrl: row (i) / word (j) sequencer for the IDDMM Montgomery datapath and its operand RAMs.
// Optional WAIT watchdog is built when IDDMM_CTRL_TIMEOUT_EN is defined; otherwise err is tied to 0.
module iddmm_ctrl #(
  parameter int N       = 32,
  parameter int ADDR_W  = $clog2(N),
  parameter int ROW_GAP = 2,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  iddmm_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   J_LAST   = (ADDR_W + 1)'(N);
  localparam int                GAP_W    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_i, w_i_nx;
  logic [ADDR_W:0]   r_j, w_j_nx;
  logic [GAP_W-1:0]  r_gap, w_gap_nx;
  logic              r_sel, w_sel_nx;
  logic              r_fifo_clr, w_fifo_clr_nx;
  logic [ADDR_W-1:0] w_j_word;
  logic [ADDR_W-1:0] w_i_dly;
  logic [ADDR_W:0]   w_j_dly;

`ifdef IDDMM_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] r_wdog;
  logic            r_err, w_err_nx;
  logic            w_wdog_expired;

  // Watchdog restarts from 0 on every entry to WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err_nx;
      if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
      else                   r_wdog <= '0;
    end
  end

  assign w_wdog_expired = (r_state == S_WAIT) && (r_wdog == WD_W'(TIMEOUT - 1));
  assign bus.err        = r_err;
`else
  // TIMEOUT only matters when the watchdog is built.
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign bus.err          = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_gap      <= '0;
      r_sel      <= 1'b0;
      r_fifo_clr <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_i        <= w_i_nx;
      r_j        <= w_j_nx;
      r_gap      <= w_gap_nx;
      r_sel      <= w_sel_nx;
      r_fifo_clr <= w_fifo_clr_nx;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nx    = r_state;
    w_i_nx        = r_i;
    w_j_nx        = r_j;
    w_gap_nx      = r_gap;
    w_sel_nx      = r_sel;
    w_fifo_clr_nx = 1'b0;
`ifdef IDDMM_CTRL_TIMEOUT_EN
    w_err_nx      = r_err;
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nx    = S_RUN;
          w_i_nx        = '0;
          w_j_nx        = '0;
          w_gap_nx      = '0;
          w_sel_nx      = 1'b0;
          w_fifo_clr_nx = 1'b1;
`ifdef IDDMM_CTRL_TIMEOUT_EN
          w_err_nx      = 1'b0;
`endif
        end
      end

      S_RUN: begin
        if (r_j == J_LAST) begin
          w_j_nx = '0;
          if (r_i == I_LAST) begin
            w_state_nx = S_WAIT;
          end else if (ROW_GAP == 0) begin
            w_i_nx = r_i + 1'b1;
          end else begin
            w_state_nx = S_GAP;
            w_gap_nx   = '0;
          end
        end else begin
          w_j_nx = r_j + 1'b1;
        end
      end

      // j stays 0 here so the datapath can finish the q update for the next row.
      S_GAP: begin
        w_j_nx = '0;
        if (r_gap == GAP_LAST) begin
          w_state_nx = S_RUN;
          w_i_nx     = r_i + 1'b1;
          w_gap_nx   = '0;
        end else begin
          w_gap_nx = r_gap + 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.cal_done) begin
          w_sel_nx   = bus.cal_sign;
          w_state_nx = S_DONE;
        end
`ifdef IDDMM_CTRL_TIMEOUT_EN
        else if (w_wdog_expired) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_DONE;
        end
`endif
      end

      // Return to IDLE presenting address 0, as after reset.
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_i_nx     = '0;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  // Counter outputs follow the RAM read latency so they line up with read data.
  generate
    if (RD_LAT == 0) begin : g_no_lat
      assign w_i_dly = r_i;
      assign w_j_dly = r_j;
    end else begin : g_lat
      logic [ADDR_W-1:0] r_i_pipe [RD_LAT];
      logic [ADDR_W:0]   r_j_pipe [RD_LAT];

      // NOTE: this small delay line is reset, unlike a RAM, because its taps are outputs that must read 0 after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < RD_LAT; k++) begin
            r_i_pipe[k] <= '0;
            r_j_pipe[k] <= '0;
          end
        end else begin
          r_i_pipe[0] <= r_i;
          r_j_pipe[0] <= r_j;
          for (int k = 1; k < RD_LAT; k++) begin
            r_i_pipe[k] <= r_i_pipe[k-1];
            r_j_pipe[k] <= r_j_pipe[k-1];
          end
        end
      end

      assign w_i_dly = r_i_pipe[RD_LAT-1];
      assign w_j_dly = r_j_pipe[RD_LAT-1];
    end
  endgenerate

  // y and p have only N words; the j = N beat reads word 0.
  assign w_j_word = (r_j == J_LAST) ? '0 : r_j[ADDR_W-1:0];

  assign bus.busy       = (r_state == S_RUN) || (r_state == S_GAP) || (r_state == S_WAIT);
  assign bus.done       = (r_state == S_DONE);
  assign bus.result_sel = r_sel;
  assign bus.fifo_clr   = r_fifo_clr;
  assign bus.x_rd_addr  = r_i;
  assign bus.y_rd_addr  = w_j_word;
  assign bus.p_rd_addr  = w_j_word;
  assign bus.a_rd_addr  = r_j;
  assign bus.i_cnt      = w_i_dly;
  assign bus.j_cnt      = w_j_dly;

endmodule

// File: tb/tb_iddmm_ctrl.sv
// Directed bench for iddmm_ctrl: N=4 with (ROW_GAP=2, RD_LAT=1) and (ROW_GAP=0, RD_LAT=0) instances.
// Per-cycle expected outputs come from row/beat arithmetic; WAIT/DONE/reset corners are hand sequences.
module tb_iddmm_ctrl;
  localparam int AW = 2;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          result_sel;
    logic          err;
    logic          fifo_clr;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [AW-1:0] p;
    logic [AW:0]   a;
    logic [AW-1:0] i_cnt;
    logic [AW:0]   j_cnt;
  } obs_t;

  typedef struct {
    logic start;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [40];
  int   n_vec;
  obs_t obs_a;
  obs_t obs_b;

  iddmm_ctrl_if #(.ADDR_W(AW)) bus_a ();
  iddmm_ctrl_if #(.ADDR_W(AW)) bus_b ();

  iddmm_ctrl #(.N(4), .ADDR_W(AW), .ROW_GAP(2), .RD_LAT(1), .TIMEOUT(16)) u_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  iddmm_ctrl #(.N(4), .ADDR_W(AW), .ROW_GAP(0), .RD_LAT(0), .TIMEOUT(16)) u_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  assign obs_a = {bus_a.busy, bus_a.done, bus_a.result_sel, bus_a.err, bus_a.fifo_clr,
                  bus_a.x_rd_addr, bus_a.y_rd_addr, bus_a.p_rd_addr, bus_a.a_rd_addr,
                  bus_a.i_cnt, bus_a.j_cnt};
  assign obs_b = {bus_b.busy, bus_b.done, bus_b.result_sel, bus_b.err, bus_b.fifo_clr,
                  bus_b.x_rd_addr, bus_b.y_rd_addr, bus_b.p_rd_addr, bus_b.a_rd_addr,
                  bus_b.i_cnt, bus_b.j_cnt};

  function automatic obs_t observe(input bit b);
    return b ? obs_b : obs_a;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0b done=%0b sel=%0b err=%0b clr=%0b x=%0d y=%0d p=%0d a=%0d i_cnt=%0d j_cnt=%0d",
                     o.busy, o.done, o.result_sel, o.err, o.fifo_clr,
                     o.x, o.y, o.p, o.a, o.i_cnt, o.j_cnt);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input logic st, input logic cd, input logic cs);
    if (b) begin
      bus_b.start = st; bus_b.cal_done = cd; bus_b.cal_sign = cs;
    end else begin
      bus_a.start = st; bus_a.cal_done = cd; bus_a.cal_sign = cs;
    end
  endtask

  // Expected issue phase for N=4: row r occupies 5+gap cycles, j = 0..4 then 0 during the gap.
  task automatic fill(input int gap, input int lat, input bit hold);
    int per, issue, ri, rj, pi, pj;
    per   = 5 + gap;
    issue = 4 * per - gap;
    n_vec = issue + 2;
    pi    = 0;
    pj    = 0;
    for (int c = 0; c < n_vec; c++) begin
      if (c < issue) begin
        ri = c / per;
        rj = (c % per <= 4) ? c % per : 0;
      end else begin
        ri = 3;
        rj = 0;
      end
      tbl[c].start        = (c == 0) || hold;
      tbl[c].exp          = '0;
      tbl[c].exp.busy     = 1'b1;
      tbl[c].exp.fifo_clr = (c == 0);
      tbl[c].exp.x        = AW'(ri);
      tbl[c].exp.y        = (rj == 4) ? '0 : AW'(rj);
      tbl[c].exp.p        = (rj == 4) ? '0 : AW'(rj);
      tbl[c].exp.a        = (AW + 1)'(rj);
      tbl[c].exp.i_cnt    = AW'(lat != 0 ? pi : ri);
      tbl[c].exp.j_cnt    = (AW + 1)'(lat != 0 ? pj : rj);
      pi = ri;
      pj = rj;
    end
  endtask

  task automatic apply_table(input string tag, input bit b, input int count);
    for (int c = 0; c < count; c++) begin
      drive(b, tbl[c].start, 1'b0, 1'b0);
      tick();
      check($sformatf("%s c%0d", tag, c), observe(b), tbl[c].exp);
    end
  endtask

  // From the last table cycle: stay in WAIT for 'waits' more cycles, then one cal_done pulse.
  task automatic finish_run(input string tag, input bit b, input int waits, input logic sign);
    obs_t e;
    e       = '0;
    e.busy  = 1'b1;
    e.x     = AW'(3);
    e.i_cnt = AW'(3);
    drive(b, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < waits; n++) begin
      tick();
      check($sformatf("%s wait%0d", tag, n), observe(b), e);
    end
    drive(b, 1'b0, 1'b1, sign);
    tick();
    drive(b, 1'b0, 1'b0, 1'b0);
    e.busy       = 1'b0;
    e.done       = 1'b1;
    e.result_sel = sign;
    check({tag, " done"}, observe(b), e);
    tick();
    e.done  = 1'b0;
    e.x     = '0;
    e.i_cnt = b ? AW'(0) : AW'(3);
    check({tag, " idle"}, observe(b), e);
  endtask

  initial begin
    obs_t e;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #11;
    check("A reset", obs_a, '0);
    check("B reset", obs_b, '0);
    #10;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // cal_done outside WAIT must be ignored.
    tick();
    check("A idle", obs_a, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("A idle cal_done", obs_a, '0);
    tick();
    check("A idle after cal_done", obs_a, '0);

    fill(2, 1, 1'b0);
    apply_table("A run1", 1'b0, n_vec);
    finish_run("A run1", 1'b0, 8, 1'b1);

    // start held through the whole run; result_sel must clear at acceptance.
    fill(2, 1, 1'b1);
    apply_table("A run2", 1'b0, n_vec);
    finish_run("A run2", 1'b0, 3, 1'b0);

    // Asynchronous reset at row 2, j = 3.
    tick();
    fill(2, 1, 1'b0);
    apply_table("A prerst", 1'b0, 18);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_a = 1'b0;
    #1;
    check("A async rst", obs_a, '0);
    tick();
    check("A in rst", obs_a, '0);
    #2;
    rst_a = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("A post rst %0d", n), obs_a, '0);
    end
    apply_table("A run3", 1'b0, n_vec);
    finish_run("A run3", 1'b0, 4, 1'b1);

    fill(0, 0, 1'b0);
    apply_table("B run", 1'b1, n_vec);
    finish_run("B run", 1'b1, 3, 1'b1);

`ifdef IDDMM_CTRL_TIMEOUT_EN
    // No cal_done: DONE 16 cycles after WAIT entry (c26 -> c42) with err set.
    fill(2, 1, 1'b0);
    apply_table("A tmo", 1'b0, n_vec);
    e       = '0;
    e.busy  = 1'b1;
    e.x     = AW'(3);
    e.i_cnt = AW'(3);
    for (int n = 0; n < 14; n++) begin
      tick();
      check($sformatf("A tmo wait%0d", n), obs_a, e);
    end
    tick();
    e.busy = 1'b0;
    e.done = 1'b1;
    e.err  = 1'b1;
    check("A tmo done", obs_a, e);
    tick();
    e.done = 1'b0;
    e.x    = '0;
    check("A tmo idle", obs_a, e);

    // cal_done on the expiry cycle (c41) wins; err cleared by the new start.
    apply_table("A tmo race", 1'b0, n_vec);
    finish_run("A tmo race", 1'b0, 14, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/iddmm_ctrl.md
Name: iddmm_ctrl

Overview:
- Sequencer for the IDDMM row/column Montgomery datapath (K-bit words, N groups).
- Runs the outer row loop (i) and the inner word loop (j) and drives the operand-RAM read addresses.
- Presents i_cnt/j_cnt to the datapath aligned with RAM read data, waits for the datapath's completion flag, and latches the final-subtraction select.
- Sits between the top-level modexp FSM (start/done handshake) and the iddmm_cal datapath plus its operand RAMs.

Parameters:
- N, 32, number of K-bit groups per operand
- ADDR_W, $clog2(N), word address width
- ROW_GAP, 2, extra cycles j_cnt is held at 0 between rows, covering q-update latency
- RD_LAT, 1, operand RAM read latency in cycles; counter outputs lag addresses by this amount
- TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- result_sel  out  1  latched cal_sign; 1 = take subtracted result FIFO, 0 = take raw result FIFO
- err  out  1  watchdog expiry flag, valid with done
- fifo_clr  out  1  one-cycle pulse on start acceptance; flushes result FIFOs
- x_rd_addr  out  ADDR_W  x word address (= row index i)
- y_rd_addr  out  ADDR_W  y word address (= j, or 0 when j = N)
- p_rd_addr  out  ADDR_W  modulus word address (same rule as y)
- a_rd_addr  out  ADDR_W+1  accumulator word address (= j)
- i_cnt  out  ADDR_W  row index to datapath, delayed RD_LAT cycles
- j_cnt  out  ADDR_W+1  column index to datapath, delayed RD_LAT cycles
- cal_done  in  1  datapath completion pulse
- cal_sign  in  1  datapath final-compare result, valid with cal_done

Behaviour:
- Reset: state = IDLE; all outputs 0, including counters, addresses, busy, done, result_sel, err, fifo_clr, and the delay-line contents.
- States: IDLE, RUN, GAP, WAIT, DONE.
- IDLE, start = 1: next cycle is RUN with i = 0, j = 0; fifo_clr pulses that same cycle; busy = 1.
- start while busy: ignored, no queueing.
- RUN: j increments 0..N each cycle, N+1 beats per row.
  - At j = N with i < N-1: enter GAP.
  - At j = N with i = N-1: enter WAIT.
- GAP: lasts ROW_GAP cycles with j held at 0, then i++, j = 0, back to RUN.
  - The datapath therefore sees j_cnt = 0 for ROW_GAP+1 consecutive cycles per row; the last one carries the valid q.
  - ROW_GAP = 0 means a direct RUN-to-RUN transition with i++.
- Addresses are combinational from the internal i/j registers.
- i_cnt/j_cnt outputs pass through an RD_LAT-stage shift register. RD_LAT = 0 means they are direct copies.
- In WAIT and DONE the internal j is 0 and i is N-1, so the delayed outputs settle to i_cnt = N-1, j_cnt = 0.
- Issue phase length: N*(N+1+ROW_GAP) - ROW_GAP cycles.
- WAIT: on cal_done, latch result_sel <= cal_sign and go to DONE.
  - A cal_done pulse in any other state is ignored.
- DONE: one cycle; done = 1, busy = 0; then IDLE.
  - result_sel holds until the next start acceptance, where it clears to 0.
- Async reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse.
- j counter width is ADDR_W+1; j = N never wraps.

Optional Feature:
- Macro IDDMM_CTRL_TIMEOUT_EN.
- Defined: a watchdog counter runs in WAIT.
  - If it reaches TIMEOUT without cal_done, go to DONE with err = 1; result_sel is unchanged (stays 0).
  - err clears on the next start acceptance.
  - cal_done arriving in the same cycle as expiry wins, and err stays 0.
- Undefined: no counter is built; WAIT is unbounded; err is tied to 0.

Test Plan:
- Reset then idle, N=4, ROW_GAP=2, RD_LAT=1: all outputs 0; pulsing cal_done in IDLE gives no done and result_sel stays 0.
- Single run, N=4, ROW_GAP=2: j_cnt sequence per row is 0,1,2,3,4,0,0, and i_cnt steps 0..3.
  - Issue phase is 26 cycles.
  - Each output lags its address by 1 cycle.
  - Drive cal_done with cal_sign = 1 ten cycles later: done pulses once and result_sel = 1.
- Back-to-back: start held high during a run is ignored.
  - A second start after done pulses fifo_clr and clears result_sel to 0 before the new run.
- ROW_GAP=0, RD_LAT=0: j_cnt goes 4 to 0 with no hold.
  - y_rd_addr = 0 when j = 4 while a_rd_addr = 4.
  - Delayed outputs equal the counters exactly.
- Reset asserted at row 2, j = 3: outputs go to 0 asynchronously; after release, no done pulse; a fresh start restarts at i = 0, j = 0.
- With IDDMM_CTRL_TIMEOUT_EN, TIMEOUT=16, no cal_done: done pulses 16 cycles into WAIT with err = 1.
  - Repeat with cal_done on the expiry cycle: err = 0 and result_sel = cal_sign.
